inst_mem: RTL and testbench
===========================

# inst_mem

Parametrised, synchronous-read instruction memory for the single-cycle/pipelined CPU fetch stage. It replaces the fixed, combinational 64-word program table with a writable array of configurable width and depth. It has a one-cycle registered fetch path with stall hold, a program-load port, and a hardware clear sequencer that fills the array with the NOP word after reset or on request.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 6, word-address width
- DEPTH, 64, number of implemented words; must satisfy DEPTH ≤ 2**ADDR_W
- NOP_WORD, 32'h00000000, fill/return value for cleared or out-of-range words (DATA_W bits)

Ports:
- clk, in, 1, single clock; all state changes on the rising edge
- rst_n, in, 1, reset; synchronous, active-low
- clr_req, in, 1, one-cycle pulse that starts a full clear; honoured only while ready=1
- ready, out, 1, high when the clear sequence is complete and the array is usable
- ld_en, in, 1, program-load write strobe
- ld_addr, in, ADDR_W, load word address
- ld_data, in, DATA_W, load data
- fetch_req, in, 1, fetch request for fetch_addr
- fetch_addr, in, ADDR_W, fetch word address (PC word index)
- fetch_stall, in, 1, holds the fetch output register
- inst_valid, out, 1, inst holds the result of an accepted fetch
- inst, out, DATA_W, fetched instruction (registered)
- addr_err, out, 1, the accepted fetch address was ≥ DEPTH; qualified by inst_valid

## Operation
- FSM states: CLEAR and READY. Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle writes NOP_WORD to array[counter], then increments the counter.
  - When the counter reaches DEPTH-1, the FSM moves to READY on the next edge.
  - ld_en, fetch_req and clr_req are ignored. inst_valid is forced to 0.
- READY:
  - clr_req=1 resets the counter to 0 and returns the FSM to CLEAR.
  - clr_req takes priority over ld_en and fetch_req in the same cycle. That cycle's load is dropped, and the fetch is not accepted.
- Load:
  - In READY with ld_en=1 and ld_addr<DEPTH, array[ld_addr] is written with ld_data.
  - A load with ld_addr≥DEPTH is silently dropped.
- Fetch acceptance: a fetch is accepted when the FSM is in READY, fetch_req=1 and fetch_stall=0.
- Fetch result, on the next edge:
  - inst_valid=1.
  - inst=array[fetch_addr], or NOP_WORD with addr_err=1 when fetch_addr≥DEPTH.
- Idle: fetch_stall=0 and fetch_req=0 gives inst_valid=0 and addr_err=0 on the next edge; inst holds its last value.
- Stall: fetch_stall=1 holds inst, inst_valid and addr_err unchanged, regardless of fetch_req. Loads still proceed.
- Load/fetch collision: a load and an accepted fetch to the same address in the same cycle is write-first, so inst=ld_data.

## Timing
- Reset values: ready=0, inst_valid=0, inst=NOP_WORD, addr_err=0, FSM=CLEAR, counter=0. Array contents are undefined until the sweep ends.
- ready rises exactly DEPTH cycles after the first edge with rst_n=1 and falls on the edge after clr_req is accepted.
- Fetch latency is 1 cycle, with a throughput of one fetch per cycle when not stalled.
- A load is visible to a fetch accepted in the same cycle (bypass) and in all later cycles.
- rst_n low mid-CLEAR or mid-stall aborts everything and re-enters the reset state on that edge.
- Counter width is ADDR_W; it never exceeds DEPTH-1, so no wrap occurs.

## Structure
- Package inst_mem_pkg holds:
  - the state enum (ST_CLEAR, ST_READY);
  - the default NOP constant;
  - a function checking the DEPTH ≤ 2**ADDR_W rule, used in an elaboration-time assertion.
- Sub-module inst_mem_ram: DEPTH×DATA_W array with one write port and one registered read port. No reset, no bypass.
- Top level holds the FSM, sweep counter, write-port mux (sweep vs load), range checks, bypass and output hold logic.

## Test plan
- Reset: release rst_n and fetch addr 0 as soon as ready rises → ready=1 at cycle 64; fetch returns inst=0x00000000, inst_valid=1, addr_err=0.
- Load then fetch: load 0x00101464@1 and 0x28003826@2, then fetch 1, 2 back-to-back → inst=0x00101464 then 0x28003826 on consecutive cycles, each with inst_valid=1.
- Stall hold: fetch 2, then hold fetch_stall=1 for 3 cycles while fetch_addr=1 → inst stays 0x28003826 with inst_valid=1; after release, the next accepted fetch yields 0x00101464.
- Collision and range (DEPTH=48, ADDR_W=6):
  - ld_en=1 with ld_addr=5, ld_data=0xDEADBEEF, and a fetch of 5 in the same cycle → inst=0xDEADBEEF.
  - Fetch 50 → inst=0x00000000, addr_err=1.
  - Load to 50 → dropped.
- Clear: pulse clr_req after programming, with a same-cycle ld_en → ready drops next cycle; fetch ignored for 64 cycles; afterwards, fetch 1 returns 0x00000000.
- Reset mid-clear: assert rst_n=0 at sweep count 20 → outputs return to reset values; ready rises 64 cycles after release.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_pkg
// Shared types and helpers for the instruction memory.
//   state_e      : sequencer state (sweep-clear vs. usable)
//   NOP_DEFAULT  : default fill word for cleared / out-of-range locations
//   depth_fits() : geometry check used at elaboration time
// ---------------------------------------------------------------------------
package inst_mem_pkg;

  // One-bit encoding: the READY code doubles as the ready flag.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // True when DEPTH words can be addressed with ADDR_W bits.
  function automatic bit depth_fits(input int depth, input int addr_w);
    longint cap;
    cap = longint'(1) << addr_w;
    return (depth >= 1) && (longint'(depth) <= cap);
  endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// ---------------------------------------------------------------------------
// inst_mem_ram
// DEPTH x DATA_W storage with one write port and one registered read port.
// Read-during-write to the same word returns the old contents; the caller
// handles any forwarding. No reset on the array or the read register.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write word address (must be < DEPTH when we_i is high)
//   wdata_i  : write data
//   re_i     : read enable; rdata_o updates only when high
//   raddr_i  : read word address (must be < DEPTH when re_i is high)
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module inst_mem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value when no read is issued, which gives the
  // fetch path its stall/idle hold for free.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem.sv
// ---------------------------------------------------------------------------
// inst_mem
// Writable, synchronous-read instruction memory for the CPU fetch stage.
// After reset (or a clr_req pulse) a sequencer sweeps NOP_WORD into every
// word; then loads and fetches are served. Fetch data appears one cycle
// after acceptance and is held while fetch_stall is high.
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst_n       : synchronous active-low reset
//   clr_req     : start a full clear (honoured only while ready)
//   ready       : array swept and usable
//   ld_en       : program-load write strobe
//   ld_addr     : load word address (loads at >= DEPTH are dropped)
//   ld_data     : load data
//   fetch_req   : fetch request for fetch_addr
//   fetch_addr  : fetch word address
//   fetch_stall : hold the fetch outputs
//   inst_valid  : inst carries the result of an accepted fetch
//   inst        : fetched instruction
//   addr_err    : accepted fetch address was >= DEPTH
// ---------------------------------------------------------------------------
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              addr_err
);

  generate
    if (!depth_fits(DEPTH, ADDR_W)) begin : g_bad_geometry
      $error("inst_mem: DEPTH must lie in 1 .. 2**ADDR_W");
    end
  endgenerate

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_READY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready = (state_q == ST_READY);

  // ---------------------------------------------------------------------
  // Qualification of the load and fetch requests
  // ---------------------------------------------------------------------
  logic in_service;
  logic ld_in_range;
  logic fetch_in_range;
  logic ld_fire;
  logic fetch_accept;
  logic collide;

  // A clear request wins over everything else in its cycle.
  assign in_service     = (state_q == ST_READY) && !clr_req;
  assign ld_in_range    = ({1'b0, ld_addr}    < DEPTH_EXT);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_EXT);
  assign ld_fire        = in_service && ld_en && ld_in_range;
  assign fetch_accept   = in_service && fetch_req && !fetch_stall;
  assign collide        = ld_fire && fetch_accept && (ld_addr == fetch_addr);

  // ---------------------------------------------------------------------
  // Write-port mux: sweep owns the port while clearing
  // ---------------------------------------------------------------------
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    ram_we    = ld_fire;
    ram_waddr = ld_addr;
    ram_wdata = ld_data;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = NOP_WORD;
    end
  end

  // Out-of-range fetches never touch the array.
  assign ram_re = fetch_accept && fetch_in_range;

  inst_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (fetch_addr),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // Fetch output registers
  // The array read register supplies normal hits; alt_q supplies the word
  // when the result must not come from the array (reset, out-of-range
  // NOP, or write-first forwarding of a colliding load).
  // ---------------------------------------------------------------------
  logic              inst_valid_q, inst_valid_d;
  logic              addr_err_q,   addr_err_d;
  logic              use_ram_q,    use_ram_d;
  logic [DATA_W-1:0] alt_q,        alt_d;

  always_comb begin
    inst_valid_d = inst_valid_q;
    addr_err_d   = addr_err_q;
    use_ram_d    = use_ram_q;
    alt_d        = alt_q;
    if (!in_service) begin
      // Clearing, or the cycle a clear is accepted.
      inst_valid_d = 1'b0;
    end else if (!fetch_stall) begin
      if (fetch_req) begin
        inst_valid_d = 1'b1;
        if (!fetch_in_range) begin
          addr_err_d = 1'b1;
          use_ram_d  = 1'b0;
          alt_d      = NOP_WORD;
        end else if (collide) begin
          addr_err_d = 1'b0;
          use_ram_d  = 1'b0;
          alt_d      = ld_data;
        end else begin
          addr_err_d = 1'b0;
          use_ram_d  = 1'b1;
        end
      end else begin
        inst_valid_d = 1'b0;
        addr_err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      use_ram_q    <= 1'b0;
      alt_q        <= NOP_WORD;
    end else begin
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      use_ram_q    <= use_ram_d;
      alt_q        <= alt_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign inst       = use_ram_q ? ram_rdata : alt_q;

endmodule

// File: tb/tb_inst_mem.sv
// ---------------------------------------------------------------------------
// tb_inst_mem
// Self-checking bench for inst_mem (DEPTH=48, ADDR_W=6, non-zero NOP word so
// cleared words are distinguishable from zero data).
// ---------------------------------------------------------------------------
module tb_inst_mem;

  localparam int          DATA_W_T = 32;
  localparam int          ADDR_W_T = 6;
  localparam int          DEPTH_T  = 48;
  localparam logic [31:0] NOP_T    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        ready;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        fetch_req;
  logic [5:0]  fetch_addr;
  logic        fetch_stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic        addr_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_mem #(
    .DATA_W   (DATA_W_T),
    .ADDR_W   (ADDR_W_T),
    .DEPTH    (DEPTH_T),
    .NOP_WORD (NOP_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_req     (clr_req),
    .ready       (ready),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .addr_err    (addr_err)
  );

  // ---------------------------------------------------------------------
  // Behavioural reference: a word array plus "cycles of clearing left".
  // Entering a clear fills the whole array at once; nothing can observe
  // the array until the clear finishes, so the gradual sweep is not modelled.
  // ---------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH_T];
  bit          m_ready;
  int          m_clear_left;
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_inst;

  task automatic model_fill_nop();
    for (int i = 0; i < DEPTH_T; i++) m_mem[i] = NOP_T;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_ready      = 1'b0;
      m_clear_left = DEPTH_T;
      m_valid      = 1'b0;
      m_err        = 1'b0;
      m_inst       = NOP_T;
      model_fill_nop();
    end else if (!m_ready) begin
      m_valid      = 1'b0;
      m_clear_left = m_clear_left - 1;
      if (m_clear_left == 0) m_ready = 1'b1;
    end else if (clr_req) begin
      m_ready      = 1'b0;
      m_clear_left = DEPTH_T;
      m_valid      = 1'b0;
      model_fill_nop();
    end else begin
      if (ld_en && (int'(ld_addr) < DEPTH_T)) m_mem[ld_addr] = ld_data;
      if (!fetch_stall) begin
        if (fetch_req) begin
          m_valid = 1'b1;
          if (int'(fetch_addr) >= DEPTH_T) begin
            m_inst = NOP_T;
            m_err  = 1'b1;
          end else begin
            m_inst = m_mem[fetch_addr];
            m_err  = 1'b0;
          end
        end else begin
          m_valid = 1'b0;
          m_err   = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, step the clock, compare to model.
  task automatic apply(input bit rn, input bit clr, input bit ld, input logic [5:0] la,
                       input logic [31:0] ldd, input bit req, input logic [5:0] fa,
                       input bit stl, input string tag);
    rst_n       = rn;
    clr_req     = clr;
    ld_en       = ld;
    ld_addr     = la;
    ld_data     = ldd;
    fetch_req   = req;
    fetch_addr  = fa;
    fetch_stall = stl;
    model_update();
    @(posedge clk);
    #1;
    chk({tag, " ready"},      32'(ready),      32'(m_ready));
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(m_valid));
    chk({tag, " inst"},       inst,            m_inst);
    if (m_valid) chk({tag, " addr_err"}, 32'(addr_err), 32'(m_err));
  endtask

  task automatic idle(input bit rn, input string tag);
    apply(rn, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, tag);
  endtask

  task automatic fetch(input logic [5:0] fa, input string tag);
    apply(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, fa, 1'b0, tag);
  endtask

  // Junk traffic during a clear; all of it must be ignored.
  task automatic junk_cycle(input string tag);
    apply(1'b1, 1'($urandom_range(0, 1)), 1'b1, 6'($urandom_range(0, 63)), $urandom,
          1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), tag);
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table (expected values written out by hand)
  // ---------------------------------------------------------------------
  typedef struct {
    bit          ld;
    logic [5:0]  la;
    logic [31:0] ldd;
    bit          req;
    logic [5:0]  fa;
    bit          stl;
    logic [31:0] e_inst;
    bit          e_valid;
    bit          e_err;
  } vec_t;

  function automatic vec_t mkv(input bit ld, input logic [5:0] la, input logic [31:0] ldd,
                               input bit req, input logic [5:0] fa, input bit stl,
                               input logic [31:0] ei, input bit ev, input bit ee);
    vec_t v;
    v.ld = ld; v.la = la; v.ldd = ldd; v.req = req; v.fa = fa; v.stl = stl;
    v.e_inst = ei; v.e_valid = ev; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    //           ld    la     ldd            req   fa     stl   inst           v     err
    tbl[0]  = mkv(1'b1, 6'd1,  32'h00101464, 1'b0, 6'd0,  1'b0, NOP_T,         1'b0, 1'b0);
    tbl[1]  = mkv(1'b1, 6'd2,  32'h28003826, 1'b1, 6'd1,  1'b0, 32'h00101464, 1'b1, 1'b0);
    tbl[2]  = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd2,  1'b0, 32'h28003826, 1'b1, 1'b0);
    tbl[3]  = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd1,  1'b1, 32'h28003826, 1'b1, 1'b0);
    tbl[4]  = mkv(1'b1, 6'd9,  32'h99999999, 1'b1, 6'd1,  1'b1, 32'h28003826, 1'b1, 1'b0);
    tbl[5]  = mkv(1'b0, 6'd0,  32'h0,        1'b0, 6'd1,  1'b1, 32'h28003826, 1'b1, 1'b0);
    tbl[6]  = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd1,  1'b0, 32'h00101464, 1'b1, 1'b0);
    tbl[7]  = mkv(1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 6'd5,  1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[8]  = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd50, 1'b0, NOP_T,         1'b1, 1'b1);
    tbl[9]  = mkv(1'b1, 6'd50, 32'h12345678, 1'b1, 6'd9,  1'b0, 32'h99999999, 1'b1, 1'b0);
    tbl[10] = mkv(1'b1, 6'd47, 32'hA5A5A5A5, 1'b1, 6'd47, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
    tbl[11] = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd48, 1'b0, NOP_T,         1'b1, 1'b1);
    tbl[12] = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd2,  1'b0, 32'h28003826, 1'b1, 1'b0);
    tbl[13] = mkv(1'b0, 6'd0,  32'h0,        1'b0, 6'd2,  1'b0, 32'h28003826, 1'b0, 1'b0);
    tbl[14] = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd5,  1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[15] = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd50, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[16] = mkv(1'b0, 6'd0,  32'h0,        1'b1, 6'd46, 1'b0, NOP_T,         1'b1, 1'b0);
  end

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; clr_req = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    m_ready = 1'b0; m_clear_left = DEPTH_T; m_valid = 1'b0; m_err = 1'b0; m_inst = NOP_T;

    // Reset state
    idle(1'b0, "rst0");
    idle(1'b0, "rst1");
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset inst_valid", 32'(inst_valid), 32'd0);
    chk("reset inst", inst, NOP_T);
    chk("reset addr_err", 32'(addr_err), 32'd0);
    $display("reset: ready=%b valid=%b inst=%h", ready, inst_valid, inst);

    // Sweep after release: ready after exactly DEPTH edges, traffic ignored
    for (int i = 0; i < DEPTH_T - 1; i++) junk_cycle("sweep");
    chk("sweep ready one early", 32'(ready), 32'd0);
    junk_cycle("sweep last");
    chk("sweep ready at DEPTH", 32'(ready), 32'd1);
    fetch(6'd0, "first fetch");
    chk("first fetch inst", inst, NOP_T);
    chk("first fetch valid", 32'(inst_valid), 32'd1);
    chk("first fetch err", 32'(addr_err), 32'd0);
    $display("first fetch: inst=%h valid=%b err=%b", inst, inst_valid, addr_err);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      apply(1'b1, 1'b0, tbl[i].ld, tbl[i].la, tbl[i].ldd, tbl[i].req, tbl[i].fa,
            tbl[i].stl, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table inst", i), inst, tbl[i].e_inst);
      chk($sformatf("vec%0d table valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d table err", i), 32'(addr_err), 32'(tbl[i].e_err));
      $display("vec%0d: inst=%h valid=%b err=%b", i, inst, inst_valid, addr_err);
    end

    // Clear with a same-cycle load and fetch: both dropped
    apply(1'b1, 1'b1, 1'b1, 6'd3, 32'h77777777, 1'b1, 6'd1, 1'b0, "clr pulse");
    chk("clr ready drops", 32'(ready), 32'd0);
    chk("clr valid drops", 32'(inst_valid), 32'd0);
    for (int i = 0; i < DEPTH_T - 1; i++) junk_cycle("clearing");
    chk("clear ready one early", 32'(ready), 32'd0);
    junk_cycle("clear last");
    chk("clear ready at DEPTH", 32'(ready), 32'd1);
    fetch(6'd1, "post-clear f1");
    chk("post-clear word1", inst, NOP_T);
    fetch(6'd3, "post-clear f3");
    chk("post-clear word3", inst, NOP_T);
    $display("after clear: inst=%h valid=%b", inst, inst_valid);

    // Reset in the middle of a clear
    apply(1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, "clr2");
    for (int i = 0; i < 20; i++) junk_cycle("clr2 sweep");
    apply(1'b0, 1'b0, 1'b1, 6'd4, 32'h44444444, 1'b1, 6'd4, 1'b0, "mid-clear rst");
    chk("mid-clear rst ready", 32'(ready), 32'd0);
    chk("mid-clear rst inst", inst, NOP_T);
    chk("mid-clear rst valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < DEPTH_T - 1; i++) idle(1'b1, "resweep");
    chk("resweep ready one early", 32'(ready), 32'd0);
    idle(1'b1, "resweep last");
    chk("resweep ready at DEPTH", 32'(ready), 32'd1);

    // Reset in the middle of a stall
    apply(1'b1, 1'b0, 1'b1, 6'd7, 32'hCAFEF00D, 1'b1, 6'd7, 1'b0, "pre-stall");
    chk("pre-stall bypass", inst, 32'hCAFEF00D);
    apply(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 1'b1, "stall");
    apply(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 1'b1, "mid-stall rst");
    chk("mid-stall rst inst", inst, NOP_T);
    chk("mid-stall rst valid", 32'(inst_valid), 32'd0);
    $display("mid-stall reset: inst=%h valid=%b", inst, inst_valid);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit          rn, clr, ld, req, stl;
      logic [5:0]  la, fa;
      rn  = ($urandom_range(0, 599) != 0);
      clr = ($urandom_range(0, 199) == 0);
      ld  = 1'($urandom_range(0, 1));
      la  = 6'($urandom_range(0, 63));
      req = ($urandom_range(0, 9) < 7);
      fa  = ($urandom_range(0, 3) == 0) ? la : 6'($urandom_range(0, 63));
      stl = ($urandom_range(0, 3) == 0);
      apply(rn, clr, ld, la, $urandom, req, fa, stl, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
